// File: rtl/tmod_pkg.sv
// Shared types for the temperature-module master controller: command opcodes,
// controller FSM states and the channel-index width helper.
package tmod_pkg;

    typedef enum logic [1:0] {
        TMOD_OP_NOOP      = 2'd0,
        TMOD_OP_RESET     = 2'd1,
        TMOD_OP_SET_FRQ   = 2'd2,
        TMOD_OP_READ_TEMP = 2'd3
    } tmod_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } tmod_mc_state_e;

    localparam int unsigned TMOD_TO_W = 16;

    // Channel index width; a single-channel build still carries a 1-bit index.
    function automatic int unsigned tmod_ch_w(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/tmod_timeout.sv
// WAIT-state cycle counter: cleared on the way into WAIT, counts each WAIT
// cycle and flags the cycle in which the TO_CYCLES-th WAIT cycle is reached.
module tmod_timeout
    import tmod_pkg::*;
#(
    parameter int TO_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMOD_TO_W-1:0] LAST_CNT = TMOD_TO_W'(TO_CYCLES - 1);

    logic [TMOD_TO_W-1:0] cnt_q;
    logic [TMOD_TO_W-1:0] cnt_d;

    // Next count: clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {TMOD_TO_W{1'b0}};
        end else if (en) begin
            cnt_d = cnt_q + {{(TMOD_TO_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {TMOD_TO_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/tmod_master_mc.sv
// Master controller issuing one command at a time to N_CH temperature modules.
// Optional WAIT timeout is enabled by defining TMOD_TIMEOUT_EN.
module tmod_master_mc
    import tmod_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DW        = 8,
    parameter int TO_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [tmod_ch_w(N_CH)-1:0]    cmd_ch,
    input  logic [DW-1:0]                 cmd_data,
    output logic                          done,
    output logic                          err,
    output logic [DW-1:0]                 rsp_data,
    output logic [N_CH-1:0]               slv_sel,
    output logic [1:0]                    slv_op,
    output logic [DW-1:0]                 slv_wdata,
    input  logic [N_CH*DW-1:0]            slv_rdata,
    input  logic [N_CH-1:0]               slv_ready
);

    localparam int CHW = tmod_ch_w(N_CH);

    tmod_mc_state_e  state_q, state_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic [CHW-1:0]  ch_q, ch_d;
    tmod_op_e        op_q, op_d;
    logic [DW-1:0]   data_q, data_d;
    logic [N_CH-1:0] sel_q, sel_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rsp_q, rsp_d;

    logic [N_CH-1:0] cmd_onehot;
    logic            cmd_ch_ok;
    logic            ch_ok;
    logic            ready_sel;
    logic [DW-1:0]   rdata_sel;
    logic            to_expired;

    // Channel decode: one-hot of the incoming channel and mux of the latched one.
    always_comb begin
        cmd_onehot = {N_CH{1'b0}};
        ready_sel  = 1'b0;
        rdata_sel  = {DW{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            cmd_onehot[i] = (cmd_ch == CHW'(i));
            ready_sel     = ready_sel | (slv_ready[i] & (ch_q == CHW'(i)));
            rdata_sel     = rdata_sel | (slv_rdata[i*DW +: DW] & {DW{ch_q == CHW'(i)}});
        end
        cmd_ch_ok = (32'(cmd_ch) < 32'(N_CH));
        ch_ok     = (32'(ch_q) < 32'(N_CH));
    end

`ifdef TMOD_TIMEOUT_EN
    logic to_clr;
    logic to_en;

    assign to_clr = (state_q == ST_ISSUE);
    assign to_en  = (state_q == ST_WAIT);

    tmod_timeout #(
        .TO_CYCLES (TO_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );
`else
    assign to_expired = 1'b0;
`endif

    // Next-state and registered-output logic. slv_sel is loaded on the accept
    // edge so the strobe lines up with the single ISSUE cycle.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        op_d    = op_q;
        data_d  = data_q;
        sel_d   = {N_CH{1'b0}};
        done_d  = 1'b0;
        err_d   = 1'b0;
        rsp_d   = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d = ST_ISSUE;
                    ch_d    = cmd_ch;
                    op_d    = tmod_op_e'(cmd_op);
                    data_d  = cmd_data;
                    if ((tmod_op_e'(cmd_op) != TMOD_OP_NOOP) && cmd_ch_ok) begin
                        sel_d = cmd_onehot;
                    end else begin
                        sel_d = {N_CH{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (op_q == TMOD_OP_NOOP) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                end else if (!ch_ok) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Ready wins over a timeout expiring in the same cycle.
                if (ready_sel) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    if (op_q == TMOD_OP_READ_TEMP) begin
                        rsp_d = rdata_sel;
                    end else begin
                        rsp_d = rsp_q;
                    end
                end else if (to_expired) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            ch_q        <= {CHW{1'b0}};
            op_q        <= TMOD_OP_NOOP;
            data_q      <= {DW{1'b0}};
            sel_q       <= {N_CH{1'b0}};
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rsp_q       <= {DW{1'b0}};
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            ch_q        <= ch_d;
            op_q        <= op_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rsp_q       <= rsp_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rsp_data  = rsp_q;
    assign slv_sel   = sel_q;
    assign slv_op    = op_q;
    assign slv_wdata = data_q;

endmodule
